// File: rtl/data_mem_responder.sv
// CPU data-memory target: word RAM plus MMIO console TX FIFO and cycle timer.
// Read data is registered (1 cycle); console drains over tx_valid/tx_ready.
module data_mem_responder #(
  parameter int          ADDR_W     = 12,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       read_data_q, read_data_d;
  logic [31:0]       timer_q, timer_d;
  logic              err_q, err_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [7:0]        fifo_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              is_mmio, aligned, wr_ok, rd_ok, ram_we;
  logic              push_req, push, pop, full, empty;
  logic [7:0]        offset;
  logic [ADDR_W-1:0] ram_idx;
  logic [2:0]        cnt_sat;
  logic [31:0]       status;

  // Address bits outside the decoded fields alias by design.
  wire unused_addr = &{1'b0, Address};

  always_comb begin
    is_mmio  = (Address[31:28] == MMIO_BASE[31:28]);
    aligned  = (Address[1:0] == 2'b00);
    offset   = Address[7:0];
    ram_idx  = Address[ADDR_W+1:2];
    wr_ok    = MemWrite && aligned;
    rd_ok    = MemRead && aligned && !MemWrite;
    ram_we   = wr_ok && !is_mmio;
    empty    = (count_q == '0);
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = !empty && tx_ready;
    push_req = wr_ok && is_mmio && (offset == 8'h04);
    // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
    push     = push_req && (!full || pop);

    if (32'(count_q) > 32'd7) cnt_sat = 3'd7;
    else                      cnt_sat = 3'(count_q);
    status = {24'd0, full, empty, 3'd0, cnt_sat};

    if (wr_ok && is_mmio && (offset == 8'h08)) timer_d = 32'd0;
    else                                        timer_d = timer_q + 32'd1;

    read_data_d = read_data_q;
    if (rd_ok) begin
      if (is_mmio) begin
        case (offset)
          8'h00:   read_data_d = status;
          8'h08:   read_data_d = timer_q;
          default: read_data_d = 32'd0;
        endcase
      end else begin
        read_data_d = mem[ram_idx];
      end
    end

    err_d = err_q
          | ((MemRead || MemWrite) && !aligned)
          | (MemRead && MemWrite)
          | (push_req && full && !pop);

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = WriteData[7:0];
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= WriteData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q <= 32'd0;
      timer_q     <= 32'd0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 8'd0;
    end else begin
      read_data_q <= read_data_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
    end
  end

  assign ReadData = read_data_q;
  assign err      = err_q;
  assign tx_valid = !empty;
  assign tx_data  = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, aliasing, console FIFO, timer, errors, reset.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] STATUS_A = 32'hF000_0000;
  localparam logic [31:0] TXDATA_A = 32'hF000_0004;
  localparam logic [31:0] TIMER_A  = 32'hF000_0008;

  data_mem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Address   (Address),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    Address = a; MemRead = 1'b1;
    tick();
    MemRead = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; Address = 32'd0; MemWrite = 1'b0; WriteData = 32'd0;
    MemRead = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    chk("rst_readdata", ReadData, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010);
    chk("ram_rd", ReadData, 32'hDEAD_BEEF);
    rd(32'h0000_4010);
    chk("ram_alias", ReadData, 32'hDEAD_BEEF);
    rd(STATUS_A);
    chk("status_empty", ReadData, 32'h0000_0040);

    wr(TXDATA_A, 32'h41);
    wr(TXDATA_A, 32'h42);
    wr(TXDATA_A, 32'h43);
    wr(TXDATA_A, 32'h44);
    chk("fill_err", {31'd0, err}, 32'd0);
    chk("fill_head", {24'd0, tx_data}, 32'h41);
    rd(STATUS_A);
    chk("status_full", ReadData, 32'h0000_0084);

    // Full FIFO: push 'F' on the same edge the head 'A' is popped.
    tx_ready = 1'b1;
    wr(TXDATA_A, 32'h46);
    tx_ready = 1'b0;
    chk("pushpop_err", {31'd0, err}, 32'd0);
    chk("pushpop_head", {24'd0, tx_data}, 32'h42);
    rd(STATUS_A);
    chk("pushpop_status", ReadData, 32'h0000_0084);

    wr(TXDATA_A, 32'h45);
    chk("overflow_err", {31'd0, err}, 32'd1);
    rd(STATUS_A);
    chk("overflow_status", ReadData, 32'h0000_0084);

    tx_ready = 1'b1;
    chk("drain0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h42});
    tick();
    chk("drain1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h43});
    tick();
    chk("drain2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h44});
    tick();
    chk("drain3", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h46});
    tick();
    chk("drain_done", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    rd(STATUS_A);
    chk("drain_status", ReadData, 32'h0000_0040);

    wr(TXDATA_A, 32'h58);
    wr(TXDATA_A, 32'h59);
    rd(32'h0000_0010);
    tx_ready = 1'b1;
    chk("refill_head", {24'd0, tx_data}, 32'h58);
    tick();
    chk("mid_drain", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h59});
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_readdata", ReadData, 32'd0);
    tx_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(STATUS_A);
    chk("arst_status", ReadData, 32'h0000_0040);

    rd(32'h0000_0010);
    chk("ram_kept", ReadData, 32'hDEAD_BEEF);
    rd(32'h0000_0002);
    chk("misalign_hold", ReadData, 32'hDEAD_BEEF);
    chk("misalign_err", {31'd0, err}, 32'd1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd(32'h0000_0010);
    Address = 32'h0000_0020; WriteData = 32'h0000_1234;
    MemRead = 1'b1; MemWrite = 1'b1;
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
    chk("rdwr_hold", ReadData, 32'hDEAD_BEEF);
    chk("rdwr_err", {31'd0, err}, 32'd1);
    rd(32'h0000_0020);
    chk("rdwr_written", ReadData, 32'h0000_1234);

    // Timer reads 0 the cycle after the clearing write, then counts up.
    wr(TIMER_A, 32'h0);
    repeat (10) tick();
    rd(TIMER_A);
    chk("timer_10", ReadData, 32'd10);
    force dut.timer_q = 32'hFFFF_FFFF;
    #1 release dut.timer_q;
    rd(TIMER_A);
    chk("timer_max", ReadData, 32'hFFFF_FFFF);
    rd(TIMER_A);
    chk("timer_wrap", ReadData, 32'd0);

    rd(32'h0000_0010);
    rd(TXDATA_A);
    chk("txdata_rd0", ReadData, 32'd0);
    rd(32'h0000_0010);
    rd(32'hF000_000C);
    chk("unmapped_rd0", ReadData, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
